issue_queue: RTL

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/ariane_pkg.sv | 20 ++
 rtl/issue_queue.sv | 69 ++++++
 2 files changed

// File: rtl/ariane_pkg.sv
// ariane_pkg: shared decode/issue types and the default issue queue depth
package ariane_pkg;
  localparam int unsigned IssueQueueDepth = 4;
  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU, FPU_VEC, CVXIF
  } fu_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  trans_id;
    fu_t         fu;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        valid;
    logic        use_imm;
    logic        ex_valid;
  } scoreboard_entry_t;
endpackage

// File: rtl/issue_queue.sv
// issue_queue: circular decode buffer with head/peek outputs and a resident control-flow cap
module issue_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH    = IssueQueueDepth,
  parameter int unsigned CF_LIMIT = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  scoreboard_entry_t        decoded_entry_i,
  input  logic                     decoded_valid_i,
  input  logic                     decoded_is_ctrl_flow_i,
  output logic                     decoded_ack_o,
  output scoreboard_entry_t        issue_entry_o,
  output logic                     issue_entry_valid_o,
  output logic                     is_ctrl_flow_o,
  input  logic                     issue_instr_ack_i,
  output scoreboard_entry_t        peek_entry_o,
  output logic                     peek_valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  scoreboard_entry_t r_mem [DEPTH];
  logic [DEPTH-1:0]  r_cf;
  logic [PW-1:0]     r_rd, r_wr;
  logic [CW-1:0]     r_cnt, r_cf_cnt;
  logic [PW-1:0]     w_rd1;
  logic              w_push, w_pop, w_cf_push, w_cf_pop;
  // accept depends only on resident state, never on the same-cycle pop
  assign w_push = decoded_valid_i & ~flush_i & (r_cnt < CW'(DEPTH))
                & ~(decoded_is_ctrl_flow_i & (r_cf_cnt == CW'(CF_LIMIT)));
  assign w_pop     = issue_instr_ack_i & issue_entry_valid_o;
  assign w_cf_push = w_push & decoded_is_ctrl_flow_i;
  assign w_cf_pop  = w_pop & r_cf[r_rd];
  assign w_rd1     = r_rd + PW'(1);
  assign decoded_ack_o       = w_push;
  assign issue_entry_valid_o = (r_cnt != '0) & ~flush_i;
  assign peek_valid_o        = (r_cnt >= CW'(2)) & ~flush_i;
  assign issue_entry_o       = r_mem[r_rd];
  assign is_ctrl_flow_o      = r_cf[r_rd];
  assign peek_entry_o        = r_mem[w_rd1];
  assign count_o             = r_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd     <= '0;
      r_wr     <= '0;
      r_cnt    <= '0;
      r_cf_cnt <= '0;
      r_cf     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      r_rd     <= '0;
      r_wr     <= '0;
      r_cnt    <= '0;
      r_cf_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= decoded_entry_i;
        r_cf[r_wr]  <= decoded_is_ctrl_flow_i;
        r_wr        <= r_wr + PW'(1);
      end
      if (w_pop) r_rd <= w_rd1;
      r_cnt    <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_cf_cnt <= r_cf_cnt + CW'(w_cf_push) - CW'(w_cf_pop);
    end
  end
endmodule
